// File: rtl/instruction_memory_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_prog_pkg
// Description : Shared constants and state encoding for the writable
//               instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_memory_prog_pkg;

    // Pipeline bubble: and r30,r30,r30
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h1FDEF2A4;

    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_RTYPE = 6'b000111;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_memory_prog_sync_ram_1r1w.sv
`default_nettype none
// ============================================================================
// Module      : sync_ram_1r1w
// Description : Storage array, one registered read port and one write port,
//               read-first on address collision.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ram_1r1w #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read and write in the same block so a collision returns the old word.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/instruction_memory_prog.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_prog
// Description : Writable instruction memory with clear-on-reset sweep,
//               bubble insertion and sticky out-of-range flag.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory_prog
    import instruction_memory_prog_pkg::*;
#(
    parameter int          DATA_W         = 32,
    parameter int          ADDR_W         = 10,
    parameter int          DEPTH          = 1024,
    parameter logic [31:0] NOP_WORD       = NOP_WORD_DEFAULT,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] endereco,
    input  logic              rd_en,
    input  logic              bolha,
    output logic [DATA_W-1:0] saida,
    output logic              saida_valid,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              busy,
    output logic              addr_err
);

    localparam int                RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [RAM_AW-1:0] c_last  = RAM_AW'(DEPTH - 1);
    localparam logic [DATA_W-1:0] c_nop   = DATA_W'(NOP_WORD);
    localparam state_t            c_rst_state = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t            state_q, state_d;
    logic [RAM_AW-1:0] cnt_q, cnt_d;
    logic              src_q, src_d;     // 1: saida shows RAM data, 0: bubble
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              w_fetch_hit;
    logic              w_prog_hit;
    logic              w_ram_re;
    logic              w_ram_we;
    logic [RAM_AW-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_fetch_hit = ({1'b0, endereco}  < c_depth);
    assign w_prog_hit  = ({1'b0, prog_addr} < c_depth);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= c_rst_state;
            cnt_q   <= '0;
            src_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        valid_d     = 1'b0;
        err_d       = err_q;
        busy        = 1'b0;
        prog_ready  = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_waddr = prog_addr[RAM_AW-1:0];
        w_ram_wdata = prog_data;

        if (rd_en && !w_fetch_hit) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_CLEAR: begin
                busy        = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_waddr = cnt_q;
                w_ram_wdata = '0;
                if (cnt_q == c_last) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + RAM_AW'(1);
                end
                if (rd_en) begin
                    src_d = 1'b0;
                end
            end
            ST_RUN: begin
                prog_ready = 1'b1;
                if (prog_valid) begin
                    if (w_prog_hit) begin
                        w_ram_we = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (rd_en) begin
                    if (!bolha && w_fetch_hit) begin
                        w_ram_re = 1'b1;
                        src_d    = 1'b1;
                        valid_d  = 1'b1;
                    end else begin
                        src_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = c_rst_state;
            end
        endcase
    end

    sync_ram_1r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk_i   (Clk),
        .re_i    (w_ram_re),
        .raddr_i (endereco[RAM_AW-1:0]),
        .rdata_o (w_ram_rdata),
        .we_i    (w_ram_we),
        .waddr_i (w_ram_waddr),
        .wdata_i (w_ram_wdata)
    );

    // RAM read register holds while rd_en is low, so saida holds too.
    assign saida       = src_q ? w_ram_rdata : c_nop;
    assign saida_valid = valid_q;
    assign addr_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_memory_prog
// Description : Scoreboard bench for instruction_memory_prog, default
//               geometry (dut_a) and DEPTH=16 (dut_b) sharing one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_memory_prog;

    localparam logic [31:0] c_nop = 32'h1FDEF2A4;

    logic        Clk;
    logic        Rst_n;
    logic [9:0]  endereco;
    logic        rd_en;
    logic        bolha;
    logic        prog_valid;
    logic [9:0]  prog_addr;
    logic [31:0] prog_data;

    logic [31:0] a_saida, b_saida;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic        a_busy,  b_busy;
    logic        a_err,   b_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [32:0] qa[$];
    logic [32:0] qb[$];
    logic        pend = 1'b0;

    instruction_memory_prog dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .endereco(endereco), .rd_en(rd_en),
        .bolha(bolha), .saida(a_saida), .saida_valid(a_valid),
        .prog_valid(prog_valid), .prog_ready(a_ready), .prog_addr(prog_addr),
        .prog_data(prog_data), .busy(a_busy), .addr_err(a_err)
    );

    instruction_memory_prog #(.DEPTH(16)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .endereco(endereco), .rd_en(rd_en),
        .bolha(bolha), .saida(b_saida), .saida_valid(b_valid),
        .prog_valid(prog_valid), .prog_ready(b_ready), .prog_addr(prog_addr),
        .prog_data(prog_data), .busy(b_busy), .addr_err(b_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a fetch sampled at a rising edge is compared on the next falling edge.
    always @(posedge Clk) pend = rd_en && Rst_n;

    always @(negedge Clk) begin
        if (pend) begin
            if (qa.size() == 0) chk("a_no_expect", {a_valid, a_saida}, 33'h1_FFFF_FFFF);
            else                chk("a_fetch", {a_valid, a_saida}, qa.pop_front());
            if (qb.size() == 0) chk("b_no_expect", {b_valid, b_saida}, 33'h1_FFFF_FFFF);
            else                chk("b_fetch", {b_valid, b_saida}, qb.pop_front());
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch(input logic [9:0] a, input logic bub,
                         input logic [32:0] ea, input logic [32:0] eb);
        endereco = a;
        bolha    = bub;
        rd_en    = 1'b1;
        qa.push_back(ea);
        qb.push_back(eb);
        tick();
        rd_en = 1'b0;
        bolha = 1'b0;
    endtask

    task automatic write(input logic [9:0] a, input logic [31:0] d);
        prog_addr  = a;
        prog_data  = d;
        prog_valid = 1'b1;
        tick();
        prog_valid = 1'b0;
    endtask

    // Call with Rst_n low; releases it and counts edges until each busy falls.
    task automatic measure_sweep(output int ka, output int kb, output int viol);
        ka = 0; kb = 0; viol = 0;
        Rst_n = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            tick();
            if (a_ready !== ~a_busy) viol++;
            if (b_ready !== ~b_busy) viol++;
            if (ka == 0 && a_busy === 1'b0) ka = k;
            if (kb == 0 && b_busy === 1'b0) kb = k;
            if (k == 2) begin
                endereco = 10'd3;
                rd_en    = 1'b1;
                qa.push_back({1'b0, c_nop});
                qb.push_back({1'b0, c_nop});
            end
            if (k == 3) rd_en = 1'b0;
            if (ka != 0 && kb != 0) break;
        end
    endtask

    int ka, kb, viol;

    initial begin
        Rst_n = 1'b0; endereco = '0; rd_en = 1'b0; bolha = 1'b0;
        prog_valid = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (3) tick();

        chk("rst_saida",   {1'b0, a_saida}, {1'b0, c_nop});
        chk("rst_valid",   {32'd0, a_valid}, 33'd0);
        chk("rst_err",     {31'd0, a_err, b_err}, 33'd0);
        chk("rst_busy",    {31'd0, a_busy, a_ready}, 33'b10);

        measure_sweep(ka, kb, viol);
        chk("sweep_len_a", 33'(ka), 33'd1024);
        chk("sweep_len_b", 33'(kb), 33'd16);
        chk("ready_vs_busy", 33'(viol), 33'd0);

        fetch(10'd5, 1'b0, {1'b1, 32'h0}, {1'b1, 32'h0});

        write(10'd0, 32'h23E01500);
        fetch(10'd0, 1'b0, {1'b1, 32'h23E01500}, {1'b1, 32'h23E01500});

        // Collision: old word comes back, new one next fetch.
        prog_addr = 10'd7; prog_data = 32'hAAAA5555; prog_valid = 1'b1;
        fetch(10'd7, 1'b0, {1'b1, 32'h0}, {1'b1, 32'h0});
        prog_valid = 1'b0;
        fetch(10'd7, 1'b0, {1'b1, 32'hAAAA5555}, {1'b1, 32'hAAAA5555});
        tick();
        chk("hold_a", {a_valid, a_saida}, {1'b0, 32'hAAAA5555});
        chk("hold_b", {b_valid, b_saida}, {1'b0, 32'hAAAA5555});

        fetch(10'd0, 1'b1, {1'b0, c_nop}, {1'b0, c_nop});

        write(10'd20, 32'hDEADBEEF);
        chk("err_after_oor_write", {31'd0, a_err, b_err}, 33'b01);
        fetch(10'd20, 1'b0, {1'b1, 32'hDEADBEEF}, {1'b0, c_nop});
        fetch(10'd4,  1'b0, {1'b1, 32'h0}, {1'b1, 32'h0});
        fetch(10'd16, 1'b0, {1'b1, 32'h0}, {1'b0, c_nop});
        fetch(10'd15, 1'b0, {1'b1, 32'h0}, {1'b1, 32'h0});
        write(10'd1023, 32'hCAFEF00D);
        fetch(10'd1023, 1'b0, {1'b1, 32'hCAFEF00D}, {1'b0, c_nop});
        repeat (3) tick();
        chk("err_sticky", {31'd0, a_err, b_err}, 33'b01);

        // Reset pulse mid-sweep.
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        repeat (300) tick();
        #3 Rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, a_busy, a_ready}, 33'b10);
        chk("midrst_err",  {31'd0, a_err, b_err}, 33'd0);
        chk("midrst_out",  {a_valid, a_saida}, {1'b0, c_nop});
        tick();
        measure_sweep(ka, kb, viol);
        chk("resweep_len_a", 33'(ka), 33'd1024);
        chk("resweep_len_b", 33'(kb), 33'd16);
        chk("resweep_ready", 33'(viol), 33'd0);

        fetch(10'd0, 1'b0, {1'b1, 32'h0}, {1'b1, 32'h0});
        fetch(10'd7, 1'b0, {1'b1, 32'h0}, {1'b1, 32'h0});
        tick();
        chk("queue_drain", 33'(qa.size() + qb.size()), 33'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_memory_prog.md
# instruction_memory_prog

Parametrised, writable instruction memory for the MIPS pipeline fetch stage. It generalises the fixed 1024×32 synchronous-read instruction ROM in three ways:
- width and depth are parameters;
- a handshaked program port lets a loader write instructions at run time;
- reset performs a hardware clear sweep, after which every unread or out-of-range fetch returns a pipeline bubble word instead of undefined data.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 10, address width.
- DEPTH, 1024, number of words; must satisfy DEPTH ≤ 2^ADDR_W.
- NOP_WORD, 32'h1FDEF2A4, bubble word (and r30,r30,r30); truncated/zero-extended to DATA_W.
- CLEAR_ON_RESET, 1, 1 = sweep memory to zero after reset; 0 = skip the sweep.

Ports (one clock; reset is asynchronous and active-low):
- Clk  in  1  clock, all state on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- endereco  in  ADDR_W  fetch address.
- rd_en  in  1  fetch request.
- bolha  in  1  force a bubble on this fetch.
- saida  out  DATA_W  fetched instruction (registered).
- saida_valid  out  1  saida holds real memory data.
- prog_valid  in  1  program-write request.
- prog_ready  out  1  program port can accept a write.
- prog_addr  in  ADDR_W  program-write address.
- prog_data  in  DATA_W  program-write data.
- busy  out  1  clear sweep in progress.
- addr_err  out  1  sticky flag: an out-of-range address was used.

## Operation
- FSM states: CLEAR and RUN.
- Reset asserted:
  - state = CLEAR if CLEAR_ON_RESET, else RUN;
  - sweep counter = 0;
  - saida = NOP_WORD, saida_valid = 0, addr_err = 0.
  - Memory array contents are not reset.
- CLEAR:
  - Each cycle writes 0 to mem[counter], then counter increments.
  - When counter = DEPTH-1 is written, go to RUN.
  - Sweep length is exactly DEPTH cycles.
  - busy = 1 and prog_ready = 0 throughout.
  - Any fetch returns saida = NOP_WORD, saida_valid = 0.
- RUN:
  - busy = 0, prog_ready = 1.
  - A write occurs on any cycle with prog_valid & prog_ready.
  - Fetch result, by priority:
    - rd_en=1, bolha=0, endereco < DEPTH: saida ← mem[endereco], saida_valid ← 1.
    - rd_en=1 and (bolha=1 or endereco ≥ DEPTH): saida ← NOP_WORD, saida_valid ← 0.
    - rd_en=0: saida holds its value, saida_valid ← 0.
- Out-of-range program write (prog_addr ≥ DEPTH): accepted (handshake completes), memory unchanged, addr_err ← 1.
- Out-of-range fetch (rd_en=1, endereco ≥ DEPTH): addr_err ← 1.
- addr_err clears only on reset.
- Simultaneous read and write to the same address is read-first: saida returns the old word; the new word is visible from the next fetch.
- Reset mid-sweep or mid-run: immediate return to reset values; the sweep restarts from address 0.

## Timing
- Fetch latency is 1 cycle: the address is sampled at edge N; saida/saida_valid are valid after edge N and stay stable until edge N+1.
- A write is sampled at the edge where prog_valid & prog_ready = 1; the data is readable by a fetch issued at the following edge.
- prog_ready is a combinational function of state only (no dependence on prog_valid).
- busy falls at the DEPTH-th rising edge after Rst_n deasserts. prog_ready rises in the same cycle busy falls.
- With CLEAR_ON_RESET = 0, busy = 0 and prog_ready = 1 immediately after reset.

## Structure
- Shared package: NOP_WORD default, opcode constants (LW 6'b001000, SW 6'b001001, R-type 6'b000111), and the state encoding (CLEAR, RUN).
- Sub-module sync_ram_1r1w(DATA_W, DEPTH): storage array with one registered read port and one write port, read-first.
- The top level holds the FSM, sweep counter, range checks, bubble mux, and the addr_err flag.

## Test plan
- Reset with defaults, hold Rst_n low then release → busy = 1 for exactly 1024 cycles, prog_ready = 0 throughout; afterwards, rd_en at address 5 → saida = 0, saida_valid = 1.
- In RUN, write 32'h23E01500 to address 0, then fetch address 0 → next cycle saida = 32'h23E01500, saida_valid = 1.
- Same cycle: write 32'hAAAA5555 to address 7 and fetch address 7, whose old value is 0 → saida = 0; the next fetch of address 7 returns 32'hAAAA5555.
- Fetch with bolha = 1 at a written address → saida = 32'h1FDEF2A4, saida_valid = 0.
- DEPTH = 16: write to address 20 and fetch address 20 → memory unchanged, saida = NOP_WORD, addr_err = 1 until the next reset.
- Pulse Rst_n low at sweep cycle 300, then release → counter restarts at 0; busy stays 1 for a further 1024 cycles.
